// File: rtl/mem_request_unit.sv
// mem_request_unit: sequences instruction-fetch and data-access requests between
// decode and the memory controller, holding each request until its hit arrives.
// Also produces the PC enable pulse, a sticky halt, a sticky watchdog timeout,
// and a count of retired instructions.
module mem_request_unit #(
    parameter int WAIT_LIMIT = 255,
    parameter int CNT_W      = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             MemRead,
    input  logic             MemWrite,
    input  logic             mem_halt,
    input  logic             ihit,
    input  logic             dhit,
    output logic             iREN,
    output logic             dREN,
    output logic             dWEN,
    output logic             PC_EN,
    output logic             halt,
    output logic             timeout,
    output logic [CNT_W-1:0] wait_cnt,
    output logic [31:0]      instr_cnt
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        DATA  = 2'd1,
        HALT  = 2'd2,
        ERR   = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(WAIT_LIMIT);

    state_t state;
    logic   fetch_retire;
    logic   data_retire;
    logic   at_limit;

    // An instruction retires on a plain fetch hit or on the data hit of a load/store;
    // reset suppresses the pulse so an abandoned request never advances the PC.
    always_comb begin
        fetch_retire = (state == FETCH) && ihit && !mem_halt && !MemRead && !MemWrite;
        data_retire  = (state == DATA) && dhit;
        at_limit     = (wait_cnt == LIMIT);
        PC_EN        = !RST && (fetch_retire || data_retire);
    end

    // Sequencer: request outputs, sticky flags, watchdog and retire count all update here.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= FETCH;
            iREN      <= 1'b1;
            dREN      <= 1'b0;
            dWEN      <= 1'b0;
            halt      <= 1'b0;
            timeout   <= 1'b0;
            wait_cnt  <= '0;
            instr_cnt <= '0;
        end else begin
            case (state)
                FETCH: begin
                    if (ihit) begin
                        wait_cnt <= '0;
                        if (mem_halt) begin
                            state <= HALT;
                            iREN  <= 1'b0;
                            halt  <= 1'b1;
                        end else if (MemWrite) begin
                            state <= DATA;
                            iREN  <= 1'b0;
                            dWEN  <= 1'b1;
                        end else if (MemRead) begin
                            state <= DATA;
                            iREN  <= 1'b0;
                            dREN  <= 1'b1;
                        end else begin
                            instr_cnt <= instr_cnt + 32'd1;
                        end
                    end else if (at_limit) begin
                        state   <= ERR;
                        iREN    <= 1'b0;
                        timeout <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (dhit) begin
                        state     <= FETCH;
                        iREN      <= 1'b1;
                        dREN      <= 1'b0;
                        dWEN      <= 1'b0;
                        wait_cnt  <= '0;
                        instr_cnt <= instr_cnt + 32'd1;
                    end else if (at_limit) begin
                        state   <= ERR;
                        dREN    <= 1'b0;
                        dWEN    <= 1'b0;
                        timeout <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= state;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_request_unit.sv
// tb_mem_request_unit: table-driven directed vectors, hand sequences for the
// counter wrap, and randomized stimulus checked against a behavioural model.
module tb_mem_request_unit;

    localparam int LIMIT = 4;

    logic        CLK = 1'b0;
    logic        RST, MemRead, MemWrite, mem_halt, ihit, dhit;
    logic        iREN, dREN, dWEN, PC_EN, halt, timeout;
    logic [7:0]  wait_cnt;
    logic [31:0] instr_cnt;

    int vec_count = 0;
    int err_count = 0;

    typedef struct {
        logic rst, rd, wr, hlt, ih, dh;
        logic pc_en;
        logic i_ren, d_ren, d_wen, halt_o, to_o;
        int   wcnt;
        int   icnt;
    } vec_t;

    vec_t vecs[$];

    // behavioural model state: what kind of access is outstanding and the bookkeeping around it
    int          m_pending;
    bit          m_halted, m_errored;
    int          m_waited;
    logic [31:0] m_retired;

    mem_request_unit #(.WAIT_LIMIT(LIMIT), .CNT_W(8)) dut (
        .CLK(CLK), .RST(RST), .MemRead(MemRead), .MemWrite(MemWrite),
        .mem_halt(mem_halt), .ihit(ihit), .dhit(dhit),
        .iREN(iREN), .dREN(dREN), .dWEN(dWEN), .PC_EN(PC_EN),
        .halt(halt), .timeout(timeout), .wait_cnt(wait_cnt), .instr_cnt(instr_cnt)
    );

    // free-running clock
    always #5 CLK = ~CLK;

    task automatic checkOutput(input string name, input longint act, input longint exp);
        vec_count++;
        if (act != exp) begin
            err_count++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // drive inputs after a falling edge, leaving time before the rising edge
    task automatic applyStimulus(input logic rst, input logic rd, input logic wr,
                                 input logic hlt, input logic ih, input logic dh);
        @(negedge CLK);
        RST = rst; MemRead = rd; MemWrite = wr; mem_halt = hlt; ihit = ih; dhit = dh;
        #1;
    endtask

    task automatic addVec(input logic rst, input logic rd, input logic wr, input logic hlt,
                          input logic ih, input logic dh, input logic pc,
                          input logic ir, input logic dr, input logic dw,
                          input logic h, input logic t, input int wc, input int ic);
        vec_t v;
        v.rst = rst; v.rd = rd; v.wr = wr; v.hlt = hlt; v.ih = ih; v.dh = dh;
        v.pc_en = pc; v.i_ren = ir; v.d_ren = dr; v.d_wen = dw;
        v.halt_o = h; v.to_o = t; v.wcnt = wc; v.icnt = ic;
        vecs.push_back(v);
    endtask

    // one model cycle computed from the sequencing rules; returns the expected PC_EN
    function automatic bit modelStep(input bit rst, input bit rd, input bit wr,
                                     input bit hlt, input bit ih, input bit dh);
        bit retire = 0;
        if (rst) begin
            m_pending = 0; m_halted = 0; m_errored = 0; m_waited = 0; m_retired = 0;
            return 0;
        end
        if (m_halted || m_errored) return 0;
        if (m_pending == 0 && ih) begin
            m_waited = 0;
            if (hlt)      m_halted = 1;
            else if (wr)  m_pending = 2;
            else if (rd)  m_pending = 1;
            else          retire = 1;
        end else if (m_pending != 0 && dh) begin
            m_waited = 0;
            m_pending = 0;
            retire = 1;
        end else if (m_waited == LIMIT) begin
            m_errored = 1;
        end else begin
            m_waited++;
        end
        if (retire) m_retired = m_retired + 1;
        return retire;
    endfunction

    initial begin
        logic        exp_pc;
        logic [31:0] all_ones;
        bit          active;
        RST = 1; MemRead = 0; MemWrite = 0; mem_halt = 0; ihit = 0; dhit = 0;

        // reset
        addVec(1,0,0,0,0,0, 0, 1,0,0,0,0, 0,0);
        // four plain fetches retire back to back
        for (int i = 1; i <= 4; i++) addVec(0,0,0,0,1,0, 1, 1,0,0,0,0, 0,i);
        // load held for three cycles, retires on dhit
        addVec(0,1,0,0,1,0, 0, 0,1,0,0,0, 0,4);
        addVec(0,0,0,0,0,0, 0, 0,1,0,0,0, 1,4);
        addVec(0,0,0,0,0,0, 0, 0,1,0,0,0, 2,4);
        addVec(0,0,0,0,0,1, 1, 1,0,0,0,0, 0,5);
        // cross-hits ignored: dhit in FETCH, ihit in DATA
        addVec(0,0,0,0,0,1, 0, 1,0,0,0,0, 1,5);
        addVec(0,0,1,0,1,0, 0, 0,0,1,0,0, 0,5);
        addVec(0,0,0,0,1,0, 0, 0,0,1,0,0, 1,5);
        addVec(0,0,0,0,0,1, 1, 1,0,0,0,0, 0,6);
        // store wins over load
        addVec(0,1,1,0,1,0, 0, 0,0,1,0,0, 0,6);
        addVec(0,0,0,0,0,1, 1, 1,0,0,0,0, 0,7);
        // halt wins over store and is sticky
        addVec(0,0,1,1,1,0, 0, 0,0,0,1,0, 0,7);
        addVec(0,0,0,0,1,0, 0, 0,0,0,1,0, 0,7);
        addVec(0,0,0,0,0,1, 0, 0,0,0,1,0, 0,7);
        addVec(1,0,0,0,0,0, 0, 1,0,0,0,0, 0,0);
        // fetch watchdog expires
        for (int i = 1; i <= 4; i++) addVec(0,0,0,0,0,0, 0, 1,0,0,0,0, i,0);
        addVec(0,0,0,0,0,0, 0, 0,0,0,0,1, 4,0);
        addVec(0,0,0,0,1,0, 0, 0,0,0,0,1, 4,0);
        addVec(1,0,0,0,0,0, 0, 1,0,0,0,0, 0,0);
        // hit exactly at the limit is accepted
        for (int i = 1; i <= 4; i++) addVec(0,0,0,0,0,0, 0, 1,0,0,0,0, i,0);
        addVec(0,0,0,0,1,0, 1, 1,0,0,0,0, 0,1);
        // data watchdog expires
        addVec(0,1,0,0,1,0, 0, 0,1,0,0,0, 0,1);
        for (int i = 1; i <= 4; i++) addVec(0,0,0,0,0,0, 0, 0,1,0,0,0, i,1);
        addVec(0,0,0,0,0,0, 0, 0,0,0,0,1, 4,1);
        addVec(1,0,0,0,0,0, 0, 1,0,0,0,0, 0,0);
        // reset during a load abandons it
        addVec(0,1,0,0,1,0, 0, 0,1,0,0,0, 0,0);
        addVec(1,0,0,0,0,1, 0, 1,0,0,0,0, 0,0);

        foreach (vecs[k]) begin
            applyStimulus(vecs[k].rst, vecs[k].rd, vecs[k].wr, vecs[k].hlt, vecs[k].ih, vecs[k].dh);
            checkOutput($sformatf("v%0d PC_EN", k), PC_EN, vecs[k].pc_en);
            @(posedge CLK); #1;
            checkOutput($sformatf("v%0d iREN", k), iREN, vecs[k].i_ren);
            checkOutput($sformatf("v%0d dREN", k), dREN, vecs[k].d_ren);
            checkOutput($sformatf("v%0d dWEN", k), dWEN, vecs[k].d_wen);
            checkOutput($sformatf("v%0d halt", k), halt, vecs[k].halt_o);
            checkOutput($sformatf("v%0d timeout", k), timeout, vecs[k].to_o);
            checkOutput($sformatf("v%0d wait_cnt", k), wait_cnt, vecs[k].wcnt);
            checkOutput($sformatf("v%0d instr_cnt", k), instr_cnt, vecs[k].icnt);
        end

        // retire count wraps from all ones to zero
        all_ones = '1;
        applyStimulus(0,0,0,0,0,0);
        force dut.instr_cnt = all_ones;
        #1;
        release dut.instr_cnt;
        #1;
        checkOutput("wrap preload", instr_cnt, all_ones);
        applyStimulus(0,0,0,0,1,0);
        checkOutput("wrap PC_EN", PC_EN, 1);
        @(posedge CLK); #1;
        checkOutput("wrap instr_cnt", instr_cnt, 0);

        // randomized run against the behavioural model
        applyStimulus(1,0,0,0,0,0);
        void'(modelStep(1,0,0,0,0,0));
        @(posedge CLK); #1;
        for (int n = 0; n < 600; n++) begin
            logic r_rst, r_rd, r_wr, r_hlt, r_ih, r_dh;
            r_rst = ($urandom_range(0, 39) == 0);
            r_rd  = $urandom_range(0, 2) == 0;
            r_wr  = $urandom_range(0, 3) == 0;
            r_hlt = $urandom_range(0, 24) == 0;
            r_ih  = $urandom_range(0, 2) == 0;
            r_dh  = $urandom_range(0, 2) == 0;
            applyStimulus(r_rst, r_rd, r_wr, r_hlt, r_ih, r_dh);
            exp_pc = modelStep(r_rst, r_rd, r_wr, r_hlt, r_ih, r_dh);
            checkOutput($sformatf("rnd%0d PC_EN", n), PC_EN, exp_pc);
            @(posedge CLK); #1;
            active = !m_halted && !m_errored;
            checkOutput($sformatf("rnd%0d iREN", n), iREN, active && m_pending == 0);
            checkOutput($sformatf("rnd%0d dREN", n), dREN, active && m_pending == 1);
            checkOutput($sformatf("rnd%0d dWEN", n), dWEN, active && m_pending == 2);
            checkOutput($sformatf("rnd%0d halt", n), halt, m_halted);
            checkOutput($sformatf("rnd%0d timeout", n), timeout, m_errored);
            checkOutput($sformatf("rnd%0d wait_cnt", n), wait_cnt, m_waited);
            checkOutput($sformatf("rnd%0d instr_cnt", n), instr_cnt, m_retired);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
        $finish;
    end

endmodule
